// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 key-event controller:
// prefix FSM states, scan-code set 2 special bytes, event and read-word layout.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kbd_state_e;

  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_EE = 8'hEE;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_FC = 8'hFC;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  localparam int EV_W = 10;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  localparam int D_VALID  = 63;
  localparam int D_OVF    = 62;
  localparam int D_SEQ    = 61;
  localparam int D_BAT    = 60;
  localparam int D_CNT_HI = 59;
  localparam int D_CNT_LO = 53;

  // Keyboard replies (ack, BAT result, echo, resend, errors) carry no key information.
  function automatic logic is_status(input logic [7:0] b);
    return (b == BYTE_00) || (b == BYTE_AA) || (b == BYTE_EE) || (b == BYTE_FA) ||
           (b == BYTE_FC) || (b == BYTE_FE) || (b == BYTE_FF);
  endfunction

endpackage

// File: rtl/kbd_event_ctrl_if.sv
// Receiver-side byte strobes and CPU-side read port of the key-event controller.
interface kbd_event_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_err;
  logic [13:0] address;
  logic        read;
  logic [63:0] data;
  logic        event_pending;

  modport master (
    output rx_valid, rx_byte, rx_err, address, read,
    input  data, event_pending
  );

  modport slave (
    input  rx_valid, rx_byte, rx_err, address, read,
    output data, event_pending
  );
endinterface

// File: rtl/kbd_event_fifo.sv
// Small synchronous FIFO of key events; a pop frees a slot for a same-cycle push.
module kbd_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/kbd_event_ctrl.sv
// PS/2 set-2 byte sequencer feeding an event FIFO, served through one
// read-to-pop bus address with sticky overflow/sequence-error/BAT flags.
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [13:0] KBD_ADDR = 14'h3fff
) (
  input logic             system_clk,
  input logic             reset,
  kbd_event_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  kbd_state_e        state_q, state_d;
  logic              read_q, read_d;
  logic [63:0]       data_q, data_d;
  logic              overflow_q, overflow_d;
  logic              seq_err_q, seq_err_d;
  logic              bat_ok_q, bat_ok_d;

  logic              push;
  kbd_event_t        push_ev;
  logic              seq_err_set;
  logic              bat_set;
  logic              pop_req;
  logic              overflow_set;
  logic [6:0]        count_ext;

  logic [EV_W-1:0]   fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  kbd_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk       (system_clk),
    .rst       (reset),
    .push      (push),
    .push_data (push_ev),
    .pop       (pop_req),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Prefix sequencer: E0/F0 accumulate, the first ordinary byte completes the event.
  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    push_ev     = '0;
    seq_err_set = 1'b0;
    bat_set     = 1'b0;
    if (bus.rx_err) begin
      state_d     = ST_IDLE;
      seq_err_set = 1'b1;
    end else if (bus.rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.rx_byte == BYTE_E0) begin
            state_d = ST_EXT;
          end else if (bus.rx_byte == BYTE_F0) begin
            state_d = ST_BRK;
          end else if (is_status(bus.rx_byte)) begin
            bat_set = (bus.rx_byte == BYTE_AA);
          end else begin
            push    = 1'b1;
            push_ev = '{brk: 1'b0, ext: 1'b0, code: bus.rx_byte};
          end
        end
        ST_EXT: begin
          if (bus.rx_byte == BYTE_F0) begin
            state_d = ST_EXT_BRK;
          end else if (bus.rx_byte != BYTE_E0) begin
            push    = 1'b1;
            push_ev = '{brk: 1'b0, ext: 1'b1, code: bus.rx_byte};
            state_d = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if ((bus.rx_byte == BYTE_E0) || (bus.rx_byte == BYTE_F0)) begin
            seq_err_set = 1'b1;
          end else begin
            push    = 1'b1;
            push_ev = '{brk: 1'b1, ext: (state_q == ST_EXT_BRK), code: bus.rx_byte};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Read word captures flags before they clear; a same-cycle set still wins afterwards.
  always_comb begin
    pop_req      = bus.read & ~read_q & (bus.address == KBD_ADDR);
    overflow_set = push & fifo_full & ~pop_req;
    read_d       = bus.read;
    count_ext    = '0;
    count_ext[CNT_W-1:0] = fifo_count;
    data_d       = data_q;
    if (pop_req) begin
      data_d                    = '0;
      data_d[D_VALID]           = ~fifo_empty;
      data_d[D_OVF]             = overflow_q;
      data_d[D_SEQ]             = seq_err_q;
      data_d[D_BAT]             = bat_ok_q;
      data_d[D_CNT_HI:D_CNT_LO] = count_ext;
      if (!fifo_empty) begin
        data_d[EV_W-1:0] = fifo_head;
      end
    end
    overflow_d = overflow_set | (overflow_q & ~pop_req);
    seq_err_d  = seq_err_set | (seq_err_q & ~pop_req);
    bat_ok_d   = bat_set | bat_ok_q;
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      read_q     <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
      bat_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      seq_err_q  <= seq_err_d;
      bat_ok_q   <= bat_ok_d;
    end
  end

  assign bus.data          = data_q;
  assign bus.event_pending = ~fifo_empty;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Self-checking bench for kbd_event_ctrl: directed scenarios then random byte/read
// traffic, all compared against a queue-based model of the key-event rules.
module tb_kbd_event_ctrl;
  import kbd_pkg::*;

  localparam int          DEPTH    = 8;
  localparam logic [13:0] KBD_ADDR = 14'h3fff;
  localparam logic [13:0] OTHER    = 14'h3ffe;

  logic clk;
  logic reset;
  kbd_event_ctrl_if bus();

  kbd_event_ctrl #(
    .DEPTH    (DEPTH),
    .KBD_ADDR (KBD_ADDR)
  ) dut (
    .system_clk (clk),
    .reset      (reset),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [9:0]  mq[$];
  bit          m_ext, m_brk, m_ovf, m_seq, m_bat, m_prev_read;
  logic [63:0] exp_data;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_seq = 0; m_bat = 0; m_prev_read = 0;
    exp_data = '0;
  endtask

  task automatic modelPush(input bit brk, input bit ext, input logic [7:0] code);
    if (mq.size() < DEPTH) mq.push_back({brk, ext, code});
    else m_ovf = 1;
  endtask

  // One clock of behaviour: the read is served first, then the byte is sequenced.
  task automatic modelStep(input logic v, input logic [7:0] b, input logic e,
                           input logic [13:0] a, input logic r);
    bit pop_req;
    pop_req = r && !m_prev_read && (a == KBD_ADDR);
    m_prev_read = r;
    if (pop_req) begin
      exp_data        = '0;
      exp_data[63]    = (mq.size() != 0);
      exp_data[62]    = m_ovf;
      exp_data[61]    = m_seq;
      exp_data[60]    = m_bat;
      exp_data[59:53] = 7'(mq.size());
      if (mq.size() != 0) exp_data[9:0] = mq.pop_front();
      m_ovf = 0;
      m_seq = 0;
    end
    if (e) begin
      m_ext = 0; m_brk = 0; m_seq = 1;
    end else if (v) begin
      if (b == 8'hE0 || b == 8'hF0) begin
        if (m_brk) begin
          m_ext = 0; m_brk = 0; m_seq = 1;
        end else if (b == 8'hE0) m_ext = 1;
        else m_brk = 1;
      end else if (!m_ext && !m_brk &&
                   (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
                    b == 8'hFC || b == 8'hFE || b == 8'hFF)) begin
        if (b == 8'hAA) m_bat = 1;
      end else begin
        modelPush(m_brk, m_ext, b);
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic e,
                               input logic [13:0] a, input logic r);
    bus.rx_valid = v;
    bus.rx_byte  = b;
    bus.rx_err   = e;
    bus.address  = a;
    bus.read     = r;
    @(posedge clk);
    modelStep(v, b, e, a, r);
    #1;
    checkOutput("data", bus.data, exp_data);
    checkOutput("event_pending", 64'(bus.event_pending), 64'(mq.size() != 0));
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0, KBD_ADDR, 1'b0);
  endtask

  task automatic readPulse(input logic [13:0] a);
    applyStimulus(1'b0, 8'h00, 1'b0, a, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, a, 1'b0);
  endtask

  task automatic doReset();
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.rx_err   = 1'b0;
    bus.address  = KBD_ADDR;
    bus.read     = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();
    #1;
    reset = 1'b0;
    checkOutput("reset_data", bus.data, 64'h0);
    checkOutput("reset_pending", 64'(bus.event_pending), 64'h0);
  endtask

  initial begin
    logic       rd;
    logic [7:0] b;
    int         sel;

    modelReset();
    doReset();

    // Single make code, then an empty FIFO afterwards.
    sendByte(8'h1C);
    readPulse(KBD_ADDR);
    checkOutput("t1_valid", 64'(bus.data[63]), 64'h1);
    checkOutput("t1_count", 64'(bus.data[59:53]), 64'h1);
    checkOutput("t1_event", 64'(bus.data[9:0]), 64'h01C);
    checkOutput("t1_pending", 64'(bus.event_pending), 64'h0);

    // Extended break and plain break.
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
    readPulse(KBD_ADDR);
    checkOutput("t2_ext_brk", 64'(bus.data[9:0]), 64'h375);
    sendByte(8'hF0); sendByte(8'h12);
    readPulse(KBD_ADDR);
    checkOutput("t2_brk", 64'(bus.data[9:0]), 64'h212);

    // Overflow with nine make codes.
    for (int i = 0; i < 9; i++) sendByte(8'h15 + 8'(i));
    readPulse(KBD_ADDR);
    checkOutput("t3_ovf_first", 64'(bus.data[62]), 64'h1);
    checkOutput("t3_count", 64'(bus.data[59:53]), 64'h8);
    checkOutput("t3_head", 64'(bus.data[9:0]), 64'h015);
    readPulse(KBD_ADDR);
    checkOutput("t3_ovf_second", 64'(bus.data[62]), 64'h0);
    checkOutput("t3_head2", 64'(bus.data[9:0]), 64'h016);
    for (int i = 0; i < 7; i++) readPulse(KBD_ADDR);
    checkOutput("t3_empty_valid", 64'(bus.data[63]), 64'h0);

    // Receiver error discards the E0 prefix.
    sendByte(8'hE0);
    applyStimulus(1'b0, 8'h00, 1'b1, KBD_ADDR, 1'b0);
    sendByte(8'h1C);
    readPulse(KBD_ADDR);
    checkOutput("t4_event", 64'(bus.data[9:0]), 64'h01C);
    checkOutput("t4_seq_err", 64'(bus.data[61]), 64'h1);

    // Held read pops once; other address has no effect.
    sendByte(8'h21); sendByte(8'h22);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, KBD_ADDR, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, KBD_ADDR, 1'b0);
    checkOutput("t5_count", 64'(bus.data[59:53]), 64'h2);
    checkOutput("t5_pending", 64'(bus.event_pending), 64'h1);
    readPulse(OTHER);
    checkOutput("t5_other_addr", 64'(bus.data[9:0]), 64'h021);
    readPulse(KBD_ADDR);
    checkOutput("t5_second", 64'(bus.data[9:0]), 64'h022);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) sendByte(8'h31 + 8'(i));
    applyStimulus(1'b1, 8'h39, 1'b0, KBD_ADDR, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, KBD_ADDR, 1'b0);
    checkOutput("t6_count", 64'(bus.data[59:53]), 64'h8);
    checkOutput("t6_head", 64'(bus.data[9:0]), 64'h031);
    for (int i = 0; i < 8; i++) readPulse(KBD_ADDR);
    checkOutput("t6_last", 64'(bus.data[9:0]), 64'h039);
    checkOutput("t6_no_ovf", 64'(bus.data[62]), 64'h0);

    // BAT completion sticks in the read word.
    sendByte(8'hAA);
    readPulse(KBD_ADDR);
    checkOutput("t7_bat", 64'(bus.data[60]), 64'h1);
    checkOutput("t7_bat_empty", 64'(bus.data[63]), 64'h0);

    // Reset mid-sequence.
    sendByte(8'hE0); sendByte(8'hF0);
    doReset();
    sendByte(8'h1C);
    readPulse(KBD_ADDR);
    checkOutput("t8_event", 64'(bus.data[9:0]), 64'h01C);
    checkOutput("t8_bat_cleared", 64'(bus.data[60]), 64'h0);

    // Random traffic.
    rd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rd = ~rd;
      sel = int'($urandom_range(0, 19));
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hAA;
        3: b = 8'hFA;
        default: b = 8'($urandom_range(1, 255));
      endcase
      applyStimulus(sel < 7, b, sel == 19,
                    ($urandom_range(0, 9) == 0) ? OTHER : KBD_ADDR, rd);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, KBD_ADDR, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) readPulse(KBD_ADDR);
    checkOutput("final_drained", 64'(bus.event_pending), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Controller between the PS/2 byte receiver and the memory-mapped bus. Sequences raw PS/2 scan-code set 2 bytes through a prefix state machine (E0 extended, F0 break), turns each complete sequence into one key event, buffers events in a small FIFO, and serves them to the CPU through a single read-to-pop address at `KBD_ADDR`. Replaces direct bus exposure of the receiver's shift register, so events are neither lost nor read twice.

## Interface
- `DEPTH`, 8: event FIFO entries (power of two, 2..64)
- `KBD_ADDR`, 14'h3fff: bus address of the event register
- `system_clk  in  1`: sole clock, rising edge
- `reset  in  1`: synchronous, active-high; clears all state on the next `system_clk` edge
- `rx_valid  in  1`: one-cycle strobe, `rx_byte` holds a complete received byte
- `rx_byte  in  8`: received byte
- `rx_err  in  1`: one-cycle strobe, receiver parity/framing error (mutually exclusive with `rx_valid`)
- `address  in  14`: bus address
- `read  in  1`: bus read strobe, level, may last several cycles
- `data  out  64`: registered read data
- `event_pending  out  1`: FIFO non-empty (interrupt level)

## Operation
- Prefix FSM states: `IDLE`, `EXT` (E0 seen), `BRK` (F0 seen), `EXT_BRK` (E0 F0 seen). Transitions apply on `rx_valid` only.
  - `IDLE`: E0 -> `EXT`; F0 -> `BRK`; status byte (00, AA, EE, FA, FC, FE, FF) -> discard, stay; AA also sets `bat_ok`. Any other byte -> push {brk=0, ext=0, code} and stay.
  - `EXT`: F0 -> `EXT_BRK`; E0 -> stay; other -> push {0, 1, code}, -> `IDLE`.
  - `BRK`: any byte other than E0/F0 -> push {1, 0, code}, -> `IDLE`; E0/F0 -> `IDLE`, set `seq_err`, no push.
  - `EXT_BRK`: non-prefix byte -> push {1, 1, code}, -> `IDLE`; E0/F0 -> `IDLE`, set `seq_err`.
  - `rx_err` in any state -> `IDLE`, set `seq_err`, no push; partial prefix discarded.
- Event = 10 bits: [9] break, [8] extended, [7:0] code.
- FIFO: count 0..`DEPTH`, write/read pointers wrap modulo `DEPTH`. Push when full -> event dropped, sticky `overflow` set, contents unchanged.
- Read handshake: a pop occurs on the first cycle of `read` high (`read & ~read_q`) with `address == KBD_ADDR`. A held `read` pops exactly once.
- `data` on pop: [63] valid (1 if FIFO was non-empty), [62] `overflow`, [61] `seq_err`, [60] `bat_ok`, [59:53] count before pop, [52:10] zero, [9:0] head event (zero if empty). Empty read: valid=0, no pointer change.
- A read clears `overflow` and `seq_err` (the values are captured in `data` first). `bat_ok` is cleared only by reset.
- Reads at any other address: `data` holds its previous value, no side effect.

## Timing
- Reset values: `data` = 64'h0, `event_pending` = 0, FSM = `IDLE`, count = 0, pointers = 0, flags = 0, `read_q` = 0.
- Byte to FIFO: event is in the FIFO and `event_pending` = 1 on the edge after the final byte's `rx_valid` cycle (1-cycle latency).
- Read: `data` valid on the edge following the read-edge cycle. `event_pending` updates on the same edge.
- Simultaneous push and pop: both take effect. Count is unchanged. If the FIFO is full, the push succeeds because the pop frees a slot. If it is empty, the pop returns valid=0 and the new event stays queued.
- A flag set and cleared in the same cycle ends up set. The reader sees the old value; the new event remains flagged.
- `reset` during a multi-byte sequence discards the prefix. It overrides a same-cycle read or push.

## Structure
- Shared package `kbd_pkg`: FSM state enum, status-byte constants (E0, F0, AA, …), event field positions, `data` bit positions.
- Sub-module `kbd_event_fifo` (parameterised `DEPTH`, width 10; push/pop/full/empty/count). Prefix FSM and bus logic live in the top.

## Test plan
- Bytes 1C; 1C pop -> `data` = valid=1, count=1, event 0x01C. Then `event_pending` = 0.
- Bytes E0 F0 75, then pop -> event 0x375. Bytes F0 12 -> event 0x212.
- Nine make codes with `DEPTH`=8 -> count 8, `overflow` set. First pop shows [62]=1 and the first code. Second pop shows [62]=0.
- E0, then `rx_err`, then 1C -> event 0x01C (not 0x11C), `seq_err` reported on that read.
- `read` held 4 cycles with 2 events queued -> one pop only, count goes 2 -> 1. Read at 14'h3ffe -> no pop, `data` unchanged.
- FIFO full plus push and pop in the same cycle -> count stays 8, no overflow, order preserved. `reset` mid E0 F0 -> all outputs 0, next 1C gives 0x01C.
